vxe_vpu_cmd_issuer: RTL
=======================

// Module: vxe_vpu_cmd_issuer
// PURPOSE
//  Command-bus transmitter on the control-unit side of the VPU command interface.
//  Accepts one command at a time from the CU dispatcher over a valid/ready input.
//  Broadcasts it to the VPU command queues selected by a destination mask.
//  Per-VPU sel/ack handshake; holds the command until every selected VPU has acked.
// PARAMETERS
//  NVPU       2   number of VPU command queues driven (1..8)
//  STALL_W    16  width of saturating stall-cycle counter
// PORTS
//  clk            in   1        clock
//  nrst           in   1        asynchronous active-low reset
//  i_vld          in   1        CU command valid
//  o_rdy          out  1        issuer can accept command this cycle
//  i_op           in   5        command opcode
//  i_th           in   3        target thread
//  i_pl           in   48       command payload
//  i_dst          in   NVPU     destination VPU mask
//  o_cmd_sel      out  NVPU     per-VPU command select
//  i_cmd_ack      in   NVPU     per-VPU command acknowledge (queue not full)
//  o_cmd_op       out  5        broadcast opcode
//  o_cmd_th       out  3        broadcast thread
//  o_cmd_pl       out  48       broadcast payload
//  o_busy         out  1        command outstanding
//  o_stall_cnt    out  STALL_W  cycles with any sel asserted and not acked
//  i_stall_clr    in   1        synchronous clear of o_stall_cnt
// BEHAVIOUR
//  Reset: state IDLE, pending=0, o_cmd_sel=0, o_cmd_op/th/pl=0, o_busy=0,
//   o_stall_cnt=0; o_rdy=1 (combinational, IDLE).
//  Transfer to VPU k completes in any cycle with o_cmd_sel[k] && i_cmd_ack[k].
//  o_cmd_sel = pending register (registered, no combinational path from ack).
//  ack_now = pending & i_cmd_ack; pend_nxt = pending & ~i_cmd_ack.
//  States:
//   IDLE : o_rdy=1. On i_vld: latch op/th/pl into output regs, pending<=i_dst;
//          i_dst!=0 -> ISSUE; i_dst==0 -> command consumed, stay IDLE, no sel.
//   ISSUE: o_busy=1. pending<=pend_nxt each cycle. o_rdy = (pend_nxt==0).
//          pend_nxt==0 && i_vld: accept next command same cycle (back-to-back),
//          load regs/pending as in IDLE; next state ISSUE if new i_dst!=0 else IDLE.
//          pend_nxt==0 && !i_vld: -> IDLE, pending=0.
//  Latency: command accepted cycle N -> o_cmd_sel asserted cycle N+1.
//  Max throughput: one command per cycle when all targets ack immediately.
//  Partial acks: acked VPUs drop sel next cycle; others keep sel, data stable.
//  o_cmd_op/th/pl stable from N+1 until all acks; never change while any sel=1.
//  i_cmd_ack on a bit with pending=0 is ignored.
//  o_busy = (state==ISSUE) registered view; drops the cycle after last ack
//   unless a new non-empty command was accepted.
//  Stall counter: increments by 1 each cycle (pending & ~i_cmd_ack)!=0;
//   saturates at all-ones; i_stall_clr has priority over increment (-> 0).
//  i_vld while o_rdy=0: ignored; CU must hold i_vld/data until o_rdy.
//  Reset asserted mid-ISSUE: sel drops immediately (async), command discarded.
// TESTING
//  1 Reset: nrst=0 -> o_cmd_sel=0, o_busy=0, o_rdy=1, o_stall_cnt=0.
//  2 Single: i_dst=2'b11, op=5'h03, pl=48'h1234, acks=11 -> sel=11 for one
//    cycle at N+1, op/pl on bus, o_busy low at N+2.
//  3 Partial: i_dst=11, ack0=1 at N+1, ack1 held 0 for 3 cycles -> sel=10 for
//    3 cycles, data stable, o_stall_cnt=3, o_rdy=1 only in ack1 cycle.
//  4 Back-to-back: 4 commands op=1..4, i_vld continuous, acks=11 -> sel=11 on
//    4 consecutive cycles, op sequence 1,2,3,4, no bubbles.
//  5 Empty mask: i_dst=0 with i_vld -> consumed in 1 cycle, no sel, o_busy=0.
//  6 Saturation/clear: STALL_W=4, ack=0 for 20 cycles -> o_stall_cnt=15;
//    i_stall_clr pulse -> 0 next cycle; nrst mid-stall -> sel=0 at once.

Source files
------------

// File: rtl/vxe_vpu_cmd_issuer.sv
// VPU command-bus issuer: takes one CU command at a time over valid/ready and
// broadcasts it to the masked VPU queues, holding it until every target has acked.

module vxe_vpu_cmd_lane (
  input  logic clk,
  input  logic nrst,
  input  logic load,
  input  logic dst,
  input  logic ack,
  output logic sel,
  output logic rem
);
  logic pend_q, pend_d;

  // An ack on a lane with nothing pending falls out of the AND and is ignored.
  always_comb begin
    rem    = pend_q & ~ack;
    pend_d = load ? dst : rem;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end

  assign sel = pend_q;
endmodule

module vxe_vpu_cmd_issuer #(
  parameter int NVPU    = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_vld,
  output logic               o_rdy,
  input  logic [4:0]         i_op,
  input  logic [2:0]         i_th,
  input  logic [47:0]        i_pl,
  input  logic [NVPU-1:0]    i_dst,
  output logic [NVPU-1:0]    o_cmd_sel,
  input  logic [NVPU-1:0]    i_cmd_ack,
  output logic [4:0]         o_cmd_op,
  output logic [2:0]         o_cmd_th,
  output logic [47:0]        o_cmd_pl,
  output logic               o_busy,
  output logic [STALL_W-1:0] o_stall_cnt,
  input  logic               i_stall_clr
);
  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  th;
    logic [47:0] pl;
  } cmd_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [NVPU-1:0]    pend_nxt;
  logic               pend_none;
  logic               accept;

  genvar g;
  generate
    for (g = 0; g < NVPU; g++) begin : g_lane
      vxe_vpu_cmd_lane u_lane (
        .clk  (clk),
        .nrst (nrst),
        .load (accept),
        .dst  (i_dst[g]),
        .ack  (i_cmd_ack[g]),
        .sel  (o_cmd_sel[g]),
        .rem  (pend_nxt[g])
      );
    end
  endgenerate

  // Ready in ISSUE as soon as this cycle's acks retire the last target,
  // which lets a new command follow with no bubble.
  always_comb begin
    pend_none = ~|pend_nxt;
    o_rdy     = (state_q == IDLE) | pend_none;
    accept    = i_vld & o_rdy;

    state_d = state_q;
    cmd_d   = cmd_q;
    if (accept) begin
      cmd_d   = '{op: i_op, th: i_th, pl: i_pl};
      state_d = (|i_dst) ? ISSUE : IDLE;
    end else if (state_q == ISSUE && pend_none) begin
      state_d = IDLE;
    end

    stall_cnt_d = stall_cnt_q;
    if (i_stall_clr)                      stall_cnt_d = '0;
    else if (!pend_none && ~&stall_cnt_q) stall_cnt_d = stall_cnt_q + STALL_W'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_cmd_op    = cmd_q.op;
  assign o_cmd_th    = cmd_q.th;
  assign o_cmd_pl    = cmd_q.pl;
  assign o_busy      = (state_q == ISSUE);
  assign o_stall_cnt = stall_cnt_q;
endmodule
